// File: rtl/z16_multicycle_ctrl.sv
// Z16 multi-cycle sequencer: owns PC/IR and steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over a single shared req/ack memory port.
module z16_multicycle_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic [3:0]  i_opecode,
  input  logic        i_rd_wen,
  input  logic        i_mem_wen,
  input  logic [15:0] i_alu_result,
  input  logic [15:0] i_store_data,
  input  logic        i_jump,
  input  logic [15:0] i_jump_addr,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_rf_wen,
  output logic [15:0] o_wb_data,
  output logic [15:0] o_retired,
  output logic        o_busy,
  output logic        o_halted,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  localparam logic [3:0]  OP_LOAD  = 4'hA;
  localparam logic [3:0]  OP_HALT  = 4'hF;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic [15:0] r_pc, r_ir, r_retired, r_tmo;
  logic [15:0] r_data;       // ALU result from EXEC, replaced by load data in MEM
  logic [15:0] r_store_data;
  logic        r_is_store;

  logic        w_retire, w_mem_req, w_mem_we, w_rf_wen, w_tmo_hit;
  logic [15:0] w_mem_addr, w_mem_wdata, w_wb_data;

  assign w_tmo_hit = (r_tmo == TMO_LAST);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_rf_wen     = 1'b0;
    w_wb_data    = '0;
    case (r_state)
      S_IDLE: if (i_run) w_state_next = S_FETCH;
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_mem_addr = r_pc;
        if (i_mem_ack)      w_state_next = S_DECODE;
        else if (w_tmo_hit) w_state_next = S_ERR;
      end
      S_DECODE: begin
        if (i_opecode == OP_HALT) begin
          w_state_next = S_HALT;
          w_retire     = 1'b1;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_opecode == OP_LOAD || i_mem_wen) w_state_next = S_MEM;
        else if (i_rd_wen)                     w_state_next = S_WB;
        else begin
          w_state_next = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      S_MEM: begin
        w_mem_req   = 1'b1;
        w_mem_we    = r_is_store;
        w_mem_addr  = r_data;
        w_mem_wdata = r_is_store ? r_store_data : 16'h0000;
        if (i_mem_ack) begin
          w_state_next = r_is_store ? S_FETCH : S_WB;
          w_retire     = r_is_store;
        end else if (w_tmo_hit) begin
          w_state_next = S_ERR;
        end
      end
      S_WB: begin
        w_rf_wen     = 1'b1;
        w_wb_data    = r_data;
        w_state_next = S_FETCH;
        w_retire     = 1'b1;
      end
      S_HALT, S_ERR: if (i_run) w_state_next = S_FETCH;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_retired    <= '0;
      r_tmo        <= '0;
      r_data       <= '0;
      r_store_data <= '0;
      r_is_store   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (r_state == S_FETCH && i_mem_ack) begin
        r_ir <= i_mem_rdata;
        r_pc <= r_pc + PC_STEP;
      end

      if (r_state == S_EXEC) begin
        if (i_jump) r_pc <= i_jump_addr;
        r_data       <= i_alu_result;
        r_store_data <= i_store_data;
        r_is_store   <= i_mem_wen;
      end

      if (r_state == S_MEM && i_mem_ack && !r_is_store) r_data <= i_mem_rdata;

      if ((r_state == S_HALT || r_state == S_ERR) && i_run) r_pc <= RESET_PC;

      if (w_retire) r_retired <= r_retired + 16'd1;

      // Count only stalled cycles within one request; any state change clears.
      if (w_mem_req && !i_mem_ack && w_state_next == r_state) r_tmo <= r_tmo + 16'd1;
      else                                                    r_tmo <= '0;
    end
  end

  assign o_mem_req   = w_mem_req;
  assign o_mem_we    = w_mem_we;
  assign o_mem_addr  = w_mem_addr;
  assign o_mem_wdata = w_mem_wdata;
  assign o_instr     = r_ir;
  assign o_pc        = r_pc;
  assign o_rf_wen    = w_rf_wen;
  assign o_wb_data   = w_wb_data;
  assign o_retired   = r_retired;
  assign o_busy      = !(r_state == S_IDLE || r_state == S_HALT || r_state == S_ERR);
  assign o_halted    = (r_state == S_HALT);
  assign o_err       = (r_state == S_ERR);

endmodule
